// File: rtl/ramb_s1_s4_fifo_ctrl.sv
// FIFO controller for an S1/S4 block RAM: 4-bit words pushed on port B, single bits popped on
// port A. Tracks fill level in bits and reports status and sticky error flags.
module ramb_s1_s4_fifo_ctrl #(
    parameter int unsigned AFULL_LVL  = 16000,
    parameter int unsigned AEMPTY_LVL = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic [3:0]  wr_data_i,
    input  logic        rd_en_i,
    input  logic        flush_i,
    output logic        rd_data_o,
    output logic        rd_valid_o,
    output logic        full_o,
    output logic        afull_o,
    output logic        empty_o,
    output logic        aempty_o,
    output logic [14:0] level_o,
    output logic        ovf_o,
    output logic        udf_o,
    output logic [11:0] ram_addrb_o,
    output logic [3:0]  ram_dib_o,
    output logic        ram_web_o,
    output logic        ram_enb_o,
    output logic [13:0] ram_addra_o,
    output logic        ram_ena_o,
    input  logic        ram_doa_i,
    output logic        ram_wea_o,
    output logic        ram_ssra_o,
    output logic        ram_ssrb_o
);

    localparam logic [14:0] AfullLvl  = 15'(AFULL_LVL);
    localparam logic [14:0] AemptyLvl = 15'(AEMPTY_LVL);

    typedef enum logic [1:0] {StIdle, StActive, StFlushing} state_e;

    state_e      state_q, state_d;
    logic [12:0] wp_q, wp_d;
    logic [14:0] rp_q, rp_d;
    logic [14:0] level_q, level_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;
    logic        rd_valid_q, rd_valid_d;
    logic [11:0] addrb_q, addrb_d;
    logic [3:0]  dib_q, dib_d;
    logic [13:0] addra_q, addra_d;

    logic full, empty, flushing, wr_acc, rd_acc;

    assign full     = level_q > 15'd16380;
    assign empty    = level_q == 15'd0;
    assign flushing = flush_i || (state_q == StFlushing);
    // Reset gating keeps the RAM enables low while RST is held.
    assign wr_acc   = wr_en_i && !full && !flushing && !rst_i;
    assign rd_acc   = rd_en_i && !empty && !flushing && !rst_i;

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        addrb_d    = addrb_q;
        dib_d      = dib_q;
        addra_d    = addra_q;
        state_d    = state_q;
        rd_valid_d = rd_acc;

        if (wr_acc) begin
            wp_d    = wp_q + 13'd1;
            addrb_d = wp_q[11:0];
            dib_d   = wr_data_i;
        end
        if (rd_acc) begin
            rp_d    = rp_q + 15'd1;
            addra_d = rp_q[13:0];
        end
        if (wr_en_i && full && !flushing) ovf_d = 1'b1;
        if (rd_en_i && empty && !flushing) udf_d = 1'b1;
        if (flush_i) begin
            wp_d  = '0;
            rp_d  = '0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        level_d = {wp_d, 2'b00} - rp_d;

        unique case (state_q)
            StIdle:     if (wr_acc) state_d = StActive;
            StActive:   if (level_d == 15'd0 && !rd_acc) state_d = StIdle;
            StFlushing: if (!flush_i) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        if (flush_i) state_d = StFlushing;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            wp_q       <= '0;
            rp_q       <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            addrb_q    <= '0;
            dib_q      <= '0;
            addra_q    <= '0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_valid_q <= rd_valid_d;
            addrb_q    <= addrb_d;
            dib_q      <= dib_d;
            addra_q    <= addra_d;
        end
    end

    // A flush in the cycle a read returns swallows that bit.
    assign rd_valid_o  = rd_valid_q && !flush_i;
    assign rd_data_o   = rd_valid_o && ram_doa_i;
    assign full_o      = full;
    assign empty_o     = empty;
    assign afull_o     = level_q >= AfullLvl;
    assign aempty_o    = level_q <= AemptyLvl;
    assign level_o     = level_q;
    assign ovf_o       = ovf_q;
    assign udf_o       = udf_q;
    assign ram_addrb_o = addrb_d;
    assign ram_dib_o   = dib_d;
    assign ram_web_o   = wr_acc;
    assign ram_enb_o   = wr_acc;
    assign ram_addra_o = addra_d;
    assign ram_ena_o   = rd_acc;
    assign ram_wea_o   = 1'b0;
    assign ram_ssra_o  = 1'b0;
    assign ram_ssrb_o  = 1'b0;

endmodule

// File: tb/tb_ramb_s1_s4_fifo_ctrl.sv
// Bench for ramb_s1_s4_fifo_ctrl: directed pushes/pops against a behavioural S1/S4 RAM, with a
// scoreboard queue of expected popped bits checked by an independent monitor.
module tb_ramb_s1_s4_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_data = 4'h0;
    logic        rd_en = 1'b0;
    logic        flush = 1'b0;
    logic        rd_data, rd_valid, full, afull, empty, aempty, ovf, udf;
    logic [14:0] level;
    logic [11:0] ram_addrb;
    logic [3:0]  ram_dib;
    logic        ram_web, ram_enb, ram_ena, ram_wea, ram_ssra, ram_ssrb;
    logic [13:0] ram_addra;
    logic        ram_doa = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;
    bit exp_q[$];
    bit mdl_q[$];
    bit fl_q = 1'b0;

    always #5 clk = ~clk;

    ramb_s1_s4_fifo_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .rd_en_i    (rd_en),
        .flush_i    (flush),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .full_o     (full),
        .afull_o    (afull),
        .empty_o    (empty),
        .aempty_o   (aempty),
        .level_o    (level),
        .ovf_o      (ovf),
        .udf_o      (udf),
        .ram_addrb_o(ram_addrb),
        .ram_dib_o  (ram_dib),
        .ram_web_o  (ram_web),
        .ram_enb_o  (ram_enb),
        .ram_addra_o(ram_addra),
        .ram_ena_o  (ram_ena),
        .ram_doa_i  (ram_doa),
        .ram_wea_o  (ram_wea),
        .ram_ssra_o (ram_ssra),
        .ram_ssrb_o (ram_ssrb)
    );

    // Behavioural block RAM: 4096 x 4 write side, 16384 x 1 read side, 1-cycle read.
    logic [3:0] mem [4096];
    always @(posedge clk) begin
        if (ram_enb && ram_web) mem[ram_addrb] <= ram_dib;
        if (ram_ena) ram_doa <= mem[ram_addra[13:2]][ram_addra[1:0]];
    end

    // Monitor: every RD_VALID must match the next expected bit.
    always @(negedge clk) begin
        if (rd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 rd_data=%0d, required no output",
                         rd_data);
            end else begin
                bit e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_fails++;
                    $display("FAIL rd_data: got %0d required %0d", rd_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // One clock with the given requests; expected pops go to the scoreboard.
    task automatic cyc(input logic w, input logic [3:0] d, input logic r, input logic f);
        bit acc_w, acc_r;
        acc_r = r && !f && !fl_q && mdl_q.size() != 0;
        acc_w = w && !f && !fl_q && mdl_q.size() <= 16380;
        if (acc_r) exp_q.push_back(mdl_q.pop_front());
        if (acc_w) for (int i = 0; i < 4; i++) mdl_q.push_back(d[i]);
        if (f) mdl_q.delete();
        fl_q = f;
        wr_en = w; wr_data = d; rd_en = r; flush = f;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_aempty"}, 32'(aempty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_afull"}, 32'(afull), 0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_rd_data"}, 32'(rd_data), 0);
        check({tag, "_ovf_udf"}, 32'({ovf, udf}), 0);
        check({tag, "_enables"}, 32'({ram_ena, ram_enb, ram_web}), 0);
        check({tag, "_addra"}, 32'(ram_addra), 0);
        check({tag, "_addrb"}, 32'(ram_addrb), 0);
        check({tag, "_dib"}, 32'(ram_dib), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check_reset_outputs("reset");
        check("const_zero", 32'({ram_wea, ram_ssra, ram_ssrb}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(0, 4'h0, 0, 0);

        // Single word, popped LSB first: 1011 -> 1,1,0,1
        cyc(1, 4'b1011, 0, 0);
        check("push_level", 32'(level), 4);
        check("push_empty", 32'(empty), 0);
        check("push_aempty", 32'(aempty), 1);
        for (int i = 0; i < 4; i++) cyc(0, 4'h0, 1, 0);
        check("pop_order_model", 32'({exp_q.size() == 0 ? 1'b0 : 1'b1}), 1);
        cyc(0, 4'h0, 0, 0);
        check("drain_level", 32'(level), 0);
        check("drain_empty", 32'(empty), 1);

        // Underflow then flush
        cyc(0, 4'h0, 1, 0);
        check("udf_set", 32'(udf), 1);
        check("udf_level", 32'(level), 0);
        cyc(0, 4'h0, 0, 1);
        cyc(0, 4'h0, 0, 0);
        check("flush_udf", 32'(udf), 0);
        check("flush_level", 32'(level), 0);

        // Concurrent push/pop from level 8
        cyc(1, 4'hA, 0, 0);
        cyc(1, 4'h5, 0, 0);
        check("lvl8", 32'(level), 8);
        for (int i = 0; i < 10; i++) cyc(1, 4'(i + 3), 1, 0);
        check("concurrent_level", 32'(level), 38);
        check("concurrent_aempty", 32'(aempty), 0);
        for (int i = 0; i < 38; i++) cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 0);
        check("concurrent_drain", 32'(level), 0);

        // Fill to full from a flushed (zero) pointer state
        cyc(0, 4'h0, 0, 1);
        cyc(0, 4'h0, 0, 0);
        for (int i = 0; i < 4096; i++) begin
            cyc(1, i[3:0], 0, 0);
            if (i == 4094) begin
                check("fill_16380_level", 32'(level), 16380);
                check("fill_16380_full", 32'(full), 0);
                check("fill_16380_afull", 32'(afull), 1);
            end
        end
        check("full_level", 32'(level), 16384);
        check("full_flag", 32'(full), 1);
        cyc(1, 4'hF, 0, 0);
        check("ovf_set", 32'(ovf), 1);
        check("ovf_level", 32'(level), 16384);

        // Pop one word, refill across the address wrap
        for (int i = 0; i < 4; i++) cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 0);
        check("unfull_level", 32'(level), 16380);
        check("unfull_flag", 32'(full), 0);
        wr_en = 1'b1; wr_data = 4'h9;
        #2;
        check("wrap_addrb", 32'(ram_addrb), 0);
        check("wrap_enb", 32'({ram_enb, ram_web}), 3);
        cyc(1, 4'h9, 0, 0);
        check("wrap_level", 32'(level), 16384);
        for (int i = 0; i < 8; i++) cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 0);
        check("wrap_pop_level", 32'(level), 16376);

        // Reset with a read in flight at level 100
        cyc(0, 4'h0, 0, 1);
        cyc(0, 4'h0, 0, 0);
        check("flush_ovf", 32'(ovf), 0);
        for (int i = 0; i < 25; i++) cyc(1, 4'hC, 0, 0);
        check("lvl100", 32'(level), 100);
        cyc(0, 4'h0, 1, 0);
        check("inflight_valid", 32'(rd_valid), 1);
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        exp_q.delete();
        mdl_q.delete();
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        rst = 1'b0;
        cyc(0, 4'h0, 0, 0);
        check("post_rst_valid", 32'(rd_valid), 0);
        check("post_rst_level", 32'(level), 0);
        cyc(0, 4'h0, 0, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ramb_s1_s4_fifo_ctrl.md
RAMB_S1_S4_FIFO_CTRL -- requirements
Module: ramb_s1_s4_fifo_ctrl

Interface
REQ-001 Parameter AFULL_LVL, default 16000, almost-full threshold in bits.
REQ-002 Parameter AEMPTY_LVL, default 16, almost-empty threshold in bits.
REQ-003 CLK  input  1  sole clock; all logic rising-edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 WR_EN  input  1  push request, one 4-bit word per cycle.
REQ-006 WR_DATA  input  4  push word; bit 0 is the first bit read out.
REQ-007 RD_EN  input  1  pop request, one bit per cycle.
REQ-008 FLUSH  input  1  synchronous clear of FIFO contents.
REQ-009 RD_DATA  output  1  popped bit, qualified by RD_VALID.
REQ-010 RD_VALID  output  1  RD_DATA valid this cycle.
REQ-011 FULL, AFULL, EMPTY, AEMPTY  output  1 each  status flags.
REQ-012 LEVEL  output  15  stored bit count, 0..16384.
REQ-013 OVF, UDF  output  1 each  sticky overflow/underflow error flags.
REQ-014 RAM_ADDRB 12, RAM_DIB 4, RAM_WEB 1, RAM_ENB 1  outputs  write port (4-bit side) of the S1/S4 block RAM.
REQ-015 RAM_ADDRA 14, RAM_ENA 1  outputs; RAM_DOA  input  1  read port (1-bit side).
REQ-016 RAM_WEA, RAM_SSRA, RAM_SSRB  outputs  1 each  driven constant 0.

Function
REQ-017 FSM states: IDLE (LEVEL=0, no pending read), ACTIVE, FLUSHING.
REQ-018 IDLE->ACTIVE on accepted write; ACTIVE->IDLE when LEVEL becomes 0 and no read is in flight; any state->FLUSHING when FLUSH=1; FLUSHING->IDLE the cycle after FLUSH deasserts.
REQ-019 Write pointer wp: 13 bits (12 address + wrap) in word units; read pointer rp: 15 bits (14 address + wrap) in bit units.
REQ-020 LEVEL = ({wp,2'b00} - rp) mod 2^15, registered, updated the same edge as the pointers.
REQ-021 FULL = (LEVEL > 16380); EMPTY = (LEVEL == 0); AFULL = (LEVEL >= AFULL_LVL); AEMPTY = (LEVEL <= AEMPTY_LVL); all flags derive from registered LEVEL.
REQ-022 Write accepted when WR_EN=1, FULL=0, state != FLUSHING: RAM_ENB=RAM_WEB=1, RAM_ADDRB=wp[11:0], RAM_DIB=WR_DATA, wp increments, wraps 4095->0 with wrap-bit toggle.
REQ-023 Read accepted when RD_EN=1, EMPTY=0, state != FLUSHING: RAM_ENA=1, RAM_ADDRA=rp[13:0], rp increments with wrap.
REQ-024 Read latency 1 cycle: RD_VALID=1 and RD_DATA=RAM_DOA on the cycle after an accepted read; RD_VALID=0 otherwise.
REQ-025 Bit mapping: bit address rp reads RAM word rp[13:2], bit rp[1:0]; order out is WR_DATA[0..3].
REQ-026 Simultaneous accepted read and write: both proceed; LEVEL changes by +3.
REQ-027 Accept decisions use pre-edge LEVEL; a write in the same cycle never makes a read acceptable when EMPTY=1.
REQ-028 Read and write never address the same RAM word in one cycle (guaranteed by REQ-021/022/023); no collision handling required.
REQ-029 WR_EN with FULL=1 is dropped and sets OVF; RD_EN with EMPTY=1 is dropped and sets UDF; neither changes pointers.
REQ-030 FLUSH=1: wp, rp, LEVEL cleared to 0 at that edge; an in-flight read's RD_VALID is suppressed; requests ignored; OVF/UDF cleared.
REQ-031 RAM enables are 0 whenever no access is accepted; addresses hold last value.

Reset
REQ-032 RST=1 asynchronously forces: state=IDLE, wp=rp=0, LEVEL=0, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, RD_VALID=0, RD_DATA=0, OVF=UDF=0, RAM_ENA=RAM_ENB=RAM_WEB=0, RAM_ADDRA=0, RAM_ADDRB=0, RAM_DIB=0.
REQ-033 Reset mid-operation discards contents and any in-flight read; no RD_VALID on the cycle after RST deasserts.

Verification
REQ-034 Push 4'b1011, then pop 4 bits -> RD_VALID 1 cycle after each pop, RD_DATA sequence 1,1,0,1; LEVEL 4->0; EMPTY returns 1.
REQ-035 Push 4096 words without pops -> LEVEL=16384, FULL=1 after word 4096 (FULL rises at LEVEL 16384); extra push -> OVF=1, LEVEL unchanged.
REQ-036 Fill to LEVEL=16384, pop 4 bits -> FULL=0 at LEVEL 16380, next push accepted at RAM_ADDRB=0 (wrap), wp wrap bit toggles.
REQ-037 From LEVEL=8, assert WR_EN and RD_EN together for 10 cycles -> LEVEL=38, pop stream unbroken and in order.
REQ-038 Pop with LEVEL=0 -> UDF=1, RD_VALID stays 0; then FLUSH -> UDF=0, LEVEL=0, state IDLE.
REQ-039 Assert RST one cycle after accepted read at LEVEL=100 -> all outputs at REQ-032 values immediately, no RD_VALID pulse, LEVEL=0.
